fp_sample_fifo: RTL
===================

FP_SAMPLE_FIFO -- requirements
Module: fp_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  converter output (S, E, F) is valid this cycle.
REQ-005 Port in_ready  output  1  FIFO can accept a code this cycle.
REQ-006 Port S  input  1  sign bit from the 12-bit-to-FP converter.
REQ-007 Port E  input  3  exponent from the converter.
REQ-008 Port F  input  4  significand from the converter.
REQ-009 Port out_valid  output  1  out_code holds the oldest stored entry.
REQ-010 Port out_ready  input  1  consumer accepts out_code this cycle.
REQ-011 Port out_code  output  8  packed entry {S,E,F}, S in bit 7.
REQ-012 Port count  output  clog2(DEPTH)+1  number of stored entries.
REQ-013 Port overflow  output  1  sticky flag: a valid input was dropped.
REQ-014 Port peak_clr  input  1  synchronous clear of the peak register.
REQ-015 Port peak_code  output  8  packed code with the largest magnitude since the last clear.

Function
REQ-016 Push SHALL occur when in_valid && in_ready; the write stores {S,E,F} at wr_ptr, and wr_ptr advances modulo DEPTH.
REQ-017 Pop SHALL occur when out_valid && out_ready; rd_ptr advances modulo DEPTH.
REQ-018 in_ready SHALL equal (count < DEPTH), decoded only from registered state, never from out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_code SHALL be mem[rd_ptr] in first-word-fall-through form.
REQ-020 Latency: a code pushed in cycle N SHALL appear on out_code with out_valid=1 in cycle N+1 if the FIFO was empty.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-022 When full, no push SHALL occur, even if a pop happens in the same cycle.
REQ-023 When empty, out_ready SHALL be ignored, and pointers and count SHALL hold.
REQ-024 in_valid && !in_ready SHALL set overflow; overflow SHALL stay at 1 until reset.
REQ-025 Entries SHALL leave in strict FIFO order; out_code SHALL stay stable while out_valid && !out_ready.
REQ-026 Peak magnitude SHALL be compared on the unsigned 7-bit key {E,F}; S is ignored in the compare.
REQ-027 On a push whose key is strictly greater than the key of peak_code, peak_code SHALL load the pushed {S,E,F}; on a tie, peak_code SHALL hold.
REQ-028 peak_clr alone SHALL set peak_code to 8'h00 next cycle; peak_clr together with a push SHALL load the pushed code.

Reset
REQ-029 rst_n=0 SHALL immediately force wr_ptr, rd_ptr, count, overflow and peak_code to 0, and therefore in_ready=1 and out_valid=0.
REQ-030 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-031 Reset deassertion SHALL take effect at the first rising clk edge while rst_n=1.

Configuration
REQ-032 Macro FP_PEAK_TRACK_EN defined: the peak register and compare logic of REQ-026..028 SHALL be built.
REQ-033 Macro FP_PEAK_TRACK_EN undefined: peak_code SHALL be tied to 8'h00 and peak_clr ignored; all ports SHALL remain present.

Verification
REQ-034 Reset, then push 8'h35 with out_ready=0 -> next cycle out_valid=1, out_code=8'h35, count=1.
REQ-035 Push 8 codes 0x01..0x08 with out_ready=0 -> count=8, in_ready=0; a 9th in_valid sets overflow=1, and pops yield 0x01..0x08 in order.
REQ-036 With the FIFO full, hold in_valid=1 and out_ready=1 for one cycle -> pop only, count=7, in_ready=1 next cycle.
REQ-037 With DEPTH=8, stream 20 codes with push and pop every cycle -> pointers wrap, count stays 1, and the output order matches the input order.
REQ-038 With FP_PEAK_TRACK_EN, push 0x9A, 0x2B, 0xAB, then pulse peak_clr together with a push of 0x11 -> peak_code goes 0x9A, 0x2B, 0x2B (tie holds), then 0x11.
REQ-039 Assert rst_n=0 mid-burst with count=5, between clock edges -> count=0, out_valid=0, overflow=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fp_sample_fifo.sv
// fp_sample_fifo: FWFT FIFO for packed {S,E,F} codes with sticky overflow; peak tracking built when FP_PEAK_TRACK_EN is defined.
module fp_sample_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     S,
  input  logic [2:0]               E,
  input  logic [3:0]               F,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_code,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     peak_clr,
  output logic [7:0]               peak_code
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] din;
  logic push, pop;
  assign din       = {S, E, F};
  assign in_ready  = count < FULL;
  assign out_valid = count != '0;
  assign out_code  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow <= overflow | (in_valid & ~in_ready);
    end
  end
`ifdef FP_PEAK_TRACK_EN
  logic [7:0] peak_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) peak_q <= 8'h00;
    else if (push && (peak_clr || din[6:0] > peak_q[6:0])) peak_q <= din;
    else if (peak_clr) peak_q <= 8'h00;
  end
  assign peak_code = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_code = 8'h00;
`endif
endmodule
